// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage load/store unit in front of a word-wide data memory.
//            Word stores go straight through in one cycle. Loads take two
//            cycles and return aligned, sign/zero-extended data. Byte and
//            halfword stores are done as read-modify-write sequences.
//            Misaligned and out-of-range requests raise one-cycle exception
//            pulses and are otherwise dropped.
// Ports    : clk, nReset (async, active low)
//            req_*          byte-addressed request from the pipeline
//            stall          hold MEM stage and earlier
//            load_valid / load_data      load result
//            misaligned / access_fault   exception pulses
//            Mem_W_En, Mem_R_En, mem_address, mem_writeData, mem_readData
//                           word-wide data memory port (1-cycle read latency)
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned,
  output logic                  access_fault,
  output logic                  Mem_W_En,
  output logic                  Mem_R_En,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  input  logic [DATA_WIDTH-1:0] mem_readData
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD_WAIT = 2'd1;
  localparam logic [1:0] S_RMW_READ  = 2'd2;
  localparam logic [1:0] S_RMW_WRITE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;

  // Request captured at acceptance; used by every non-IDLE state.
  logic [ADDR_WIDTH-1:0] r_word_addr;
  logic [1:0]            r_lane;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [15:0]           r_wdata;
  logic [31:0]           r_merge;

  logic                  w_misaligned;
  logic                  w_fault;
  logic                  w_legal;
  logic                  w_word_store;
  logic [31:0]           w_merge;
  logic [31:0]           w_load_data;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  // --------------------------------------------------------------------------
  // Request checks (only meaningful in IDLE)
  // --------------------------------------------------------------------------
  always_comb begin
    w_misaligned = (req_size == 2'b11)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    // Misalignment takes priority; any address bit above the memory is a fault.
    w_fault      = !w_misaligned && (|req_addr[31:ADDR_WIDTH+2]);
    w_legal      = req_valid && !w_misaligned && !w_fault;
    w_word_store = w_legal && req_write && (req_size == SZ_WORD);
  end

  // --------------------------------------------------------------------------
  // Load alignment/extension and RMW merge, both from the captured request
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte = mem_readData[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? mem_readData[31:16] : mem_readData[15:0];
    case (r_size)
      SZ_BYTE: w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load_data = mem_readData;
    endcase

    w_merge = mem_readData;
    if (r_size == SZ_BYTE) begin
      w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_legal && !w_word_store) begin
          w_next_state = req_write ? S_RMW_READ : S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: w_next_state = S_IDLE;
      S_RMW_READ:  w_next_state = S_RMW_WRITE;
      S_RMW_WRITE: w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // Everything is forced to its reset value while nReset is low, so a reset
  // landing mid-sequence (or on a live request) never produces an enable.
  // --------------------------------------------------------------------------
  always_comb begin
    stall         = 1'b0;
    load_valid    = 1'b0;
    load_data     = '0;
    misaligned    = 1'b0;
    access_fault  = 1'b0;
    Mem_W_En      = 1'b0;
    Mem_R_En      = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    if (nReset) begin
      case (r_state)
        S_IDLE: begin
          mem_address  = req_addr[ADDR_WIDTH+1:2];
          misaligned   = req_valid && w_misaligned;
          access_fault = req_valid && w_fault;
          if (w_word_store) begin
            Mem_W_En      = 1'b1;
            mem_writeData = req_wdata;
          end else if (w_legal) begin
            // Loads and sub-word stores both start with a read.
            Mem_R_En = 1'b1;
            stall    = 1'b1;
          end
        end
        S_LOAD_WAIT: begin
          mem_address = r_word_addr;
          load_valid  = 1'b1;
          load_data   = w_load_data;
        end
        S_RMW_READ: begin
          mem_address = r_word_addr;
          stall       = 1'b1;
        end
        S_RMW_WRITE: begin
          mem_address   = r_word_addr;
          Mem_W_En      = 1'b1;
          mem_writeData = r_merge;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Request capture and merge register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_word_addr <= '0;
      r_lane      <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_wdata     <= '0;
      r_merge     <= '0;
    end else begin
      if (r_state == S_IDLE && w_legal && !w_word_store) begin
        r_word_addr <= req_addr[ADDR_WIDTH+1:2];
        r_lane      <= req_addr[1:0];
        r_size      <= req_size;
        r_unsigned  <= req_unsigned;
        r_wdata     <= req_wdata[15:0];
      end
      if (r_state == S_RMW_READ) begin
        r_merge <= w_merge;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the five-stage pipeline, sitting directly upstream of the word-wide data memory. It takes the pipeline's byte-addressed load/store request with a size and signedness, and drives the memory's word address, read/write enables and write data. It implements byte and halfword stores as read-modify-write sequences, and aligns and extends load data. It stalls the pipeline while a multi-cycle access is in flight and flags misaligned or out-of-range accesses.

## Interface
- DATA_WIDTH, 32, data word width; fixed at 32 for byte-lane logic
- ADDR_WIDTH, 10, word-address width toward data memory
- clk  in  1  clock, rising edge
- nReset  in  1  asynchronous active-low reset
- req_valid  in  1  memory request present in MEM stage
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  hold MEM stage and earlier; request must stay stable while high
- load_valid  out  1  load result valid this cycle
- load_data  out  32  aligned, extended load result
- misaligned  out  1  one-cycle exception pulse
- access_fault  out  1  one-cycle exception pulse
- Mem_W_En  out  1  memory write enable
- Mem_R_En  out  1  memory read enable
- mem_address  out  ADDR_WIDTH  word address
- mem_writeData  out  32  word to write
- mem_readData  in  32  memory read data, valid the cycle after Mem_R_En

## Operation
- FSM states: IDLE, LOAD_WAIT, RMW_READ, RMW_WRITE. Reset state is IDLE.
- **Word address:** req_addr[ADDR_WIDTH+1:2]. Byte lane is req_addr[1:0], little-endian.
- **Checks (IDLE, req_valid):**
  - misaligned = half with addr[0]=1, or word with addr[1:0]≠0, or size=11.
  - Otherwise access_fault = any bit of addr[31:ADDR_WIDTH+2] set.
  - misaligned has priority over access_fault.
  - Faulting requests produce no enables, no stall and no load_valid, and the FSM stays in IDLE.
- **Word store:** in IDLE, Mem_W_En=1 combinationally, with mem_writeData=req_wdata. No stall; FSM stays in IDLE.
- **Load:**
  - IDLE cycle: Mem_R_En=1, stall=1. Capture addr, size and unsigned into registers; go to LOAD_WAIT.
  - LOAD_WAIT: load_valid=1, stall=0. load_data is extracted from mem_readData:
    - byte: lane addr[1:0], bit 7 extended;
    - half: lane addr[1], bit 15 extended;
    - word: unchanged.
  - Then go to IDLE.
- **Byte/half store:**
  - IDLE cycle: Mem_R_En=1, stall=1. Capture addr, size and wdata; go to RMW_READ.
  - RMW_READ: stall=1. Register merge = mem_readData with the target lane(s) replaced by wdata[7:0] or wdata[15:0]; go to RMW_WRITE.
  - RMW_WRITE: Mem_W_En=1, mem_writeData=merge, stall=0; go to IDLE.
- In non-IDLE states, mem_address comes from the captured register and request inputs are ignored.
- load_data is 0 whenever load_valid=0. Mem_W_En and Mem_R_En are never high together.
- **Reset mid-operation:** FSM goes to IDLE immediately. A pending RMW write is dropped; memory is not written.

## Timing
- Reset values: stall 0, load_valid 0, load_data 0, misaligned 0, access_fault 0, Mem_W_En 0, Mem_R_En 0, mem_address 0, mem_writeData 0.
- **Latency:**
  - Word store: 1 cycle, no stall.
  - Load: 2 cycles, 1 stall cycle; data arrives in the second cycle.
  - Sub-word store: 3 cycles, 2 stall cycles; memory is written on the clock edge ending RMW_WRITE.
- Stall is combinational from state and request in IDLE, and from state elsewhere.
- The pipeline advances at the edge ending a stall=0 cycle. A back-to-back request is accepted in the following IDLE cycle; there is no dead cycle beyond that.
- Exceptions are combinational in the request cycle and last 1 cycle.

## Test plan
- **Word round trip:** store 0xDEADBEEF to addr 0x10, then load word from 0x10 → no stall on the store; load stalls 1 cycle, then load_valid with 0xDEADBEEF.
- **Byte store merge:** after the above, store byte 0x5A to 0x11 → stall high for 2 cycles, Mem_W_En pulses with 0xDEAD5AEF; a subsequent load word returns 0xDEAD5AEF.
- **Sign/zero extension:** word 0x80F0_7F81 at 0x20:
  - signed byte at 0x20 → 0xFFFFFF81;
  - unsigned byte at 0x20 → 0x00000081;
  - signed half at 0x22 → 0xFFFF80F0;
  - unsigned half at 0x22 → 0x000080F0.
- **Exceptions:**
  - half at 0x21, word at 0x22, size=11 → misaligned pulse, no enables, no stall.
  - word at 0x1000 (ADDR_WIDTH=10) → access_fault pulse, no enables.
- **Reset mid-RMW:** assert nReset low during RMW_READ → all outputs go to reset values immediately, Mem_W_En is never asserted, and state is IDLE after release.
- **Back-to-back:** byte store then immediate load to the same word → the load is issued the cycle after RMW_WRITE and returns the merged value.
